vga_sync_generator: RTL
=======================

Name: vga_sync_generator

Overview:
Consumer end of the pixel-rate timing produced by clock_divider. Runs on boardCLK and advances one pixel on every cycle where the pixelEN strobe is high; pixelEN is clock_divider's vga rate expressed as an enable, so there is no second clock domain. Generates hsync, vsync, the active-video flag, the current pixel coordinates, and line and frame ticks for the renderer and game logic. Defaults are 640x480 at 60 Hz (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_HIGH, 0, 0 = sync pulses driven low, 1 = driven high

Ports:
boardCLK  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
pixelEN  in  1  pixel-advance strobe; may be a single-cycle pulse or held high
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
videoON  out  1  high while the current position is in the active region, registered
pixelX  out  10  current horizontal count, 0..H_TOTAL-1
pixelY  out  10  current vertical count, 0..V_TOTAL-1
lineTick  out  1  one-boardCLK pulse when hcount wraps
frameTick  out  1  one-boardCLK pulse when both counters wrap

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = the corresponding vertical sum. Both must be <= 1024. Elaboration fails otherwise.
- Reset has priority over pixelEN. On reset:
  - hcount = 0, vcount = 0; both phase FSMs go to ACTIVE.
  - hsync and vsync go to their inactive level (1 when SYNC_ACTIVE_HIGH=0).
  - videoON = 1, pixelX = 0, pixelY = 0, lineTick = 0, frameTick = 0.
- Reset asserted mid-frame returns to (0,0) on the next edge and discards any partial line.
- Cycles with pixelEN=0: all state and all level outputs hold; lineTick and frameTick are 0.
- Cycles with pixelEN=1:
  - hcount increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcount increments and wraps V_TOTAL-1 -> 0.
  - Counters update on the same edge.
- Horizontal phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Transitions occur on the advancing edge where the next hcount equals H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and 0 respectively.
- Vertical phase FSM: same four states over vcount with the V_* boundaries. It steps only on hcount wraps.
- Level outputs are registered from next-state and next-count values, so they always match the current pixelX/pixelY with zero added latency:
  - hsync is active iff the horizontal state is SYNC (default: hcount 656..751).
  - vsync is active iff the vertical state is SYNC (default: vcount 490..491).
  - videoON = both states are ACTIVE.
- lineTick = 1 for exactly the cycle after the advancing edge on which hcount became 0.
- frameTick = 1 for the same cycle only when vcount also became 0.
- frameTick implies lineTick.
- pixelEN held high continuously is legal: one pixel per boardCLK, and ticks stay single-cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - the phase enum {ACTIVE, FRONT, SYNC, BACK};
  - the default 640x480 constants and the derived H_TOTAL/V_TOTAL functions;
  - the coordinate width (10).
- One sub-module, sync_axis_counter, is instantiated twice (horizontal and vertical).
  - Inputs: advance.
  - Parameters: active/fp/sync/bp.
  - Outputs: count, phase, wrap.
- The vertical instance's advance = horizontal wrap AND pixelEN.

Test Plan:
- Reset held 3 cycles with pixelEN=1 -> pixelX=0, pixelY=0, hsync=1, vsync=1, videoON=1, ticks 0.
- pixelEN every 4th boardCLK (25 MHz from 100 MHz) for one line -> videoON falls at pixelX=640; hsync low exactly for pixelX 656..751 (96 enables); lineTick pulses once, 1 boardCLK wide, after 800 enables.
- pixelEN held high for 800*525 cycles -> vsync low only on lines 490..491; exactly 525 lineTicks; one frameTick as the count returns to (0,0).
- pixelEN low for 50 cycles at pixelX=700, pixelY=100 -> all outputs frozen, no ticks; resumes at 701.
- Reset pulsed at pixelX=660, pixelY=491 (hsync and vsync both active) -> next edge gives (0,0), syncs inactive, no tick.
- Stop at pixelX=799, pixelY=479 and apply one enable -> pixelY=480, videoON=0, lineTick=1, frameTick=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: phase encoding, default 640x480@60 timing and coordinate width shared by the VGA sync blocks
package vga_timing_pkg;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
    localparam int COORD_W = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 33;
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    function automatic int h_total();
        return axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    endfunction
    function automatic int v_total();
        return axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    endfunction
endpackage

// File: rtl/sync_axis_counter.sv
// sync_axis_counter: one timing axis; wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK phase
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int FP_LEN = DEF_H_FP,
    parameter int SYNC_LEN = DEF_H_SYNC,
    parameter int BP_LEN = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output phase_t             phase_next,
    output logic               wrap
);
    localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] FRONT_AT = COORD_W'(ACTIVE_LEN);
    localparam logic [COORD_W-1:0] SYNC_AT = COORD_W'(ACTIVE_LEN + FP_LEN);
    localparam logic [COORD_W-1:0] BACK_AT = COORD_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);
    if (TOTAL > MAX_TOTAL) begin : g_too_long
        $fatal(1, "sync_axis_counter: axis total %0d exceeds %0d", TOTAL, MAX_TOTAL);
    end
    logic [COORD_W-1:0] count_q, count_d;
    phase_t phase_q, phase_d;
    // phase is decoded from the next count so it lines up with the count it describes
    always_comb begin
        wrap = advance && count_q == LAST;
        count_d = !advance ? count_q : wrap ? '0 : count_q + 1'b1;
        phase_d = phase_q;
        if (advance)
            phase_d = count_d == FRONT_AT ? FRONT :
                      count_d == SYNC_AT  ? SYNC  :
                      count_d == BACK_AT  ? BACK  :
                      count_d == '0       ? ACTIVE : phase_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end
    assign count = count_q;
    assign phase_next = phase_d;
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: pixel-enable driven VGA timing with registered syncs, active flag, coordinates and line/frame ticks
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic               boardCLK,
    input  logic               reset,
    input  logic               pixelEN,
    output logic               hsync,
    output logic               vsync,
    output logic               videoON,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    output logic               lineTick,
    output logic               frameTick
);
    logic h_wrap, v_wrap, v_advance;
    phase_t h_phase_d, v_phase_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;
    sync_axis_counter #(
        .ACTIVE_LEN(H_ACTIVE),
        .FP_LEN(H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN(H_BP)
    ) u_h (
        .clk(boardCLK),
        .rst(reset),
        .advance(pixelEN),
        .count(pixelX),
        .phase_next(h_phase_d),
        .wrap(h_wrap)
    );
    assign v_advance = h_wrap && pixelEN;
    sync_axis_counter #(
        .ACTIVE_LEN(V_ACTIVE),
        .FP_LEN(V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN(V_BP)
    ) u_v (
        .clk(boardCLK),
        .rst(reset),
        .advance(v_advance),
        .count(pixelY),
        .phase_next(v_phase_d),
        .wrap(v_wrap)
    );
    // levels come from next phases so they share the edge on which pixelX/pixelY update
    always_comb begin
        hsync_d = (h_phase_d == SYNC) ~^ SYNC_ACTIVE_HIGH;
        vsync_d = (v_phase_d == SYNC) ~^ SYNC_ACTIVE_HIGH;
        video_on_d = h_phase_d == ACTIVE && v_phase_d == ACTIVE;
        line_tick_d = h_wrap;
        frame_tick_d = v_wrap;
    end
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            hsync_q <= !SYNC_ACTIVE_HIGH;
            vsync_q <= !SYNC_ACTIVE_HIGH;
            video_on_q <= 1'b1;
            line_tick_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_on_q <= video_on_d;
            line_tick_q <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign videoON = video_on_q;
    assign lineTick = line_tick_q;
    assign frameTick = frame_tick_q;
endmodule
